disp_scan_8seg: RTL and testbench

- Time-multiplexed scanner for a common-cathode multi-digit 8-segment display; sits directly upstream of the per-digit BCD/hex-to-segment decoder.
- Holds a double-buffered hex value and dot mask, and walks through the digits at a fixed slot rate.
- Per slot it drives one nibble (tetrade), its dot bit, the decoder output-enable (oe) and a one-hot digit select, with programmable blanking and leading-zero suppression.

---
 rtl/disp_scan_8seg_if.sv | 15 +
 rtl/disp_scan_8seg.sv | 55 +++++
 tb/tb_disp_scan_8seg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/disp_scan_8seg_if.sv
// disp_scan_8seg_if: load port and decoder-side outputs of the digit scanner
interface disp_scan_8seg_if #(parameter int NDIGITS = 8);
  logic wr;
  logic [4*NDIGITS-1:0] wdata;
  logic [NDIGITS-1:0] wdot;
  logic lz_en;
  logic [3:0] tetrade;
  logic dot;
  logic oe;
  logic [NDIGITS-1:0] dig_sel;
  logic frame;
  logic pend;
  modport master (output wr, wdata, wdot, lz_en, input tetrade, dot, oe, dig_sel, frame, pend);
  modport slave (input wr, wdata, wdot, lz_en, output tetrade, dot, oe, dig_sel, frame, pend);
endinterface

// File: rtl/disp_scan_8seg.sv
// disp_scan_8seg: multiplexed digit scanner feeding a per-digit hex-to-segment decoder
module disp_scan_8seg #(
  parameter int NDIGITS = 8,
  parameter int DIV = 1000,
  parameter int BLANK = 16
) (
  input logic clk,
  input logic rst_n,
  disp_scan_8seg_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NDIGITS-1:0] act_val, pnd_val;
  logic [NDIGITS-1:0] act_dot, pnd_dot;
  logic slot_end, frame_end, hi_nz, vis;
  assign slot_end = cnt == CW'(DIV - 1);
  assign frame_end = slot_end && idx == IW'(NDIGITS - 1);
  // any nonzero nibble or dot at or above the current digit keeps it lit
  always_comb begin
    hi_nz = 1'b0;
    for (int i = 0; i < NDIGITS; i++)
      hi_nz = hi_nz | (IW'(i) >= idx && ((|act_val[4*i+:4]) || act_dot[i]));
  end
  assign vis = cnt >= CW'(BLANK) && (!bus.lz_en || idx == '0 || hi_nz);
  // active only changes at frame end; a write landing on that cycle bypasses pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      act_val <= '0;
      act_dot <= '0;
      pnd_val <= '0;
      pnd_dot <= '0;
      bus.pend <= 1'b0;
      bus.frame <= 1'b0;
      bus.oe <= 1'b0;
      bus.dig_sel <= '0;
      bus.tetrade <= '0;
      bus.dot <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
      if (frame_end && (bus.wr || bus.pend))
        {act_val, act_dot} <= bus.wr ? {bus.wdata, bus.wdot} : {pnd_val, pnd_dot};
      if (bus.wr) {pnd_val, pnd_dot} <= {bus.wdata, bus.wdot};
      bus.pend <= !frame_end && (bus.wr || bus.pend);
      bus.frame <= frame_end;
      bus.oe <= vis;
      bus.dig_sel <= vis ? NDIGITS'(1) << idx : '0;
      bus.tetrade <= vis ? act_val[4*idx+:4] : '0;
      bus.dot <= vis && act_dot[idx];
    end
endmodule

// File: tb/tb_disp_scan_8seg.sv
// tb_disp_scan_8seg: directed scan sequences with a cycle-level scoreboard (4 digits, DIV=8, BLANK=2)
module tb_disp_scan_8seg;
  typedef struct packed {
    logic [3:0] tet;
    logic dot;
    logic oe;
    logic [3:0] sel;
    logic frame;
    logic pend;
  } out_t;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  out_t q[$];
  int m_cnt, m_idx;
  logic [15:0] m_val, p_val;
  logic [3:0] m_dot, p_dot;
  logic m_pend;
  logic [15:0] t;
  logic [3:0] d, o;
  logic sel_ok;
  int n;
  disp_scan_8seg_if #(.NDIGITS(4)) bus ();
  disp_scan_8seg #(.NDIGITS(4), .DIV(8), .BLANK(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic out_t observed();
    return '{bus.tetrade, bus.dot, bus.oe, bus.dig_sel, bus.frame, bus.pend};
  endfunction
  // reference model: expected outputs come from pre-edge state, pend from post-edge state
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_val = '0; m_dot = '0; p_val = '0; p_dot = '0; m_pend = 1'b0;
      q.delete();
    end else begin
      out_t e;
      logic fe;
      e.oe = m_cnt >= 2 && (!bus.lz_en || m_idx == 0 || (m_val >> (4 * m_idx)) != 0 || (m_dot >> m_idx) != 0);
      e.sel = e.oe ? 4'(1 << m_idx) : 4'b0;
      e.tet = e.oe ? 4'(m_val >> (4 * m_idx)) : 4'b0;
      e.dot = e.oe ? m_dot[m_idx] : 1'b0;
      fe = m_cnt == 7 && m_idx == 3;
      e.frame = fe;
      if (fe && bus.wr) begin m_val = bus.wdata; m_dot = bus.wdot; end
      else if (fe && m_pend) begin m_val = p_val; m_dot = p_dot; end
      if (bus.wr) begin p_val = bus.wdata; p_dot = bus.wdot; end
      if (fe) m_pend = 1'b0;
      else if (bus.wr) m_pend = 1'b1;
      e.pend = m_pend;
      m_cnt = (m_cnt + 1) % 8;
      if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
      q.push_back(e);
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && q.size() > 0) chk("scoreboard", 32'(observed()), 32'(q.pop_front()));
  end
  task automatic write(input logic [15:0] v, input logic [3:0] dm);
    bus.wr = 1'b1; bus.wdata = v; bus.wdot = dm;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask
  task automatic wait_frame(output int cycles);
    cycles = 1;
    @(negedge clk);
    while (bus.frame !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    chk("frame_seen", 32'(bus.frame), 32'd1);
  endtask
  // called on the negedge showing frame=1; samples the mid-slot cycle of each digit
  task automatic scan(output logic [15:0] tv, output logic [3:0] dv, output logic [3:0] ov, output logic ok);
    tv = '0; dv = '0; ov = '0; ok = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      tv[4*s+:4] = bus.tetrade;
      dv[s] = bus.dot;
      ov[s] = bus.oe;
      if (bus.dig_sel !== (bus.oe ? 4'(1 << s) : 4'b0)) ok = 1'b0;
      if (s < 3) repeat (8) @(negedge clk);
    end
  endtask
  task automatic release_chk();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("blank_oe", 32'(bus.oe), 32'd0);
    chk("blank_sel", 32'(bus.dig_sel), 32'd0);
    @(negedge clk);
    chk("first_oe", 32'(bus.oe), 32'd1);
    chk("first_sel", 32'(bus.dig_sel), 32'd1);
    chk("first_tet", 32'(bus.tetrade), 32'd0);
    chk("first_pend", 32'(bus.pend), 32'd0);
  endtask
  initial begin
    bus.wr = 1'b0; bus.wdata = '0; bus.wdot = '0; bus.lz_en = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_outs", 32'(observed()), 32'd0);
    repeat (2) @(negedge clk);
    release_chk();
    wait_frame(n);
    wait_frame(n);
    chk("frame_period", 32'(n), 32'd32);
    repeat (5) @(negedge clk);
    write(16'h12AF, 4'b0100);
    chk("pend_rise", 32'(bus.pend), 32'd1);
    wait_frame(n);
    chk("pend_clear", 32'(bus.pend), 32'd0);
    scan(t, d, o, sel_ok);
    chk("scan_12af", 32'(t), 32'h12AF);
    chk("dot_12af", 32'(d), 32'b0100);
    chk("oe_12af", 32'(o), 32'b1111);
    chk("sel_12af", 32'(sel_ok), 32'd1);
    wait_frame(n);
    repeat (3) @(negedge clk);
    write(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    write(16'h2222, 4'b0000);
    wait_frame(n);
    scan(t, d, o, sel_ok);
    chk("last_write_wins", 32'(t), 32'h2222);
    wait_frame(n);
    repeat (31) @(negedge clk);
    write(16'h0ABC, 4'b0000);
    chk("coinc_frame", 32'(bus.frame), 32'd1);
    chk("coinc_pend", 32'(bus.pend), 32'd0);
    scan(t, d, o, sel_ok);
    chk("coinc_scan", 32'(t), 32'h0ABC);
    chk("coinc_oe", 32'(o), 32'b1111);
    bus.lz_en = 1'b1;
    write(16'h0005, 4'b0000);
    wait_frame(n);
    scan(t, d, o, sel_ok);
    chk("lz5_oe", 32'(o), 32'b0001);
    chk("lz5_tet", 32'(t), 32'h0005);
    chk("lz5_sel", 32'(sel_ok), 32'd1);
    write(16'h0000, 4'b0000);
    wait_frame(n);
    scan(t, d, o, sel_ok);
    chk("lz0_oe", 32'(o), 32'b0001);
    chk("lz0_tet", 32'(t), 32'h0000);
    write(16'h0000, 4'b0100);
    wait_frame(n);
    scan(t, d, o, sel_ok);
    chk("lzdot_oe", 32'(o), 32'b0111);
    chk("lzdot_dot", 32'(d), 32'b0100);
    chk("lzdot_sel", 32'(sel_ok), 32'd1);
    bus.lz_en = 1'b0;
    write(16'h1234, 4'b0011);
    chk("pre_rst_pend", 32'(bus.pend), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(observed()), 32'd0);
    @(negedge clk);
    release_chk();
    wait_frame(n);
    scan(t, d, o, sel_ok);
    chk("post_rst_val", 32'(t), 32'h0000);
    chk("post_rst_oe", 32'(o), 32'b1111);
    chk("post_rst_dot", 32'(d), 32'b0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
